// File: rtl/disp_pkg.sv
// Shared types for the multiplexed display scan capture.
// Segment decode table, FSM encoding, stability limits.
package disp_pkg;

  localparam int STABLE_MIN = 2;
  localparam int STABLE_MAX = 255;

  localparam logic [0:0] ST_HUNT    = 1'b0;
  localparam logic [0:0] ST_CAPTURE = 1'b1;

  typedef struct packed {
    logic       ok;
    logic [3:0] val;
  } seg_dec_t;

  typedef struct packed {
    logic       ok;
    logic [1:0] idx;
  } an_dec_t;

  // Active-low segments a..g in bits 0..6.
  function automatic seg_dec_t seg_decode(
    input logic [6:0] s
  );
    seg_dec_t r;
    r.ok  = 1'b1;
    r.val = 4'h0;
    case (s)
      7'h40: r.val = 4'd0;
      7'h79: r.val = 4'd1;
      7'h24: r.val = 4'd2;
      7'h30: r.val = 4'd3;
      7'h19: r.val = 4'd4;
      7'h12: r.val = 4'd5;
      7'h02: r.val = 4'd6;
      7'h78: r.val = 4'd7;
      7'h00: r.val = 4'd8;
      7'h10: r.val = 4'd9;
      default: begin
        r.ok  = 1'b0;
        r.val = 4'hF;
      end
    endcase
    return r;
  endfunction

  // Exactly one low anode bit is a legal select.
  function automatic an_dec_t an_decode(
    input logic [3:0] an
  );
    an_dec_t r;
    r.ok  = 1'b1;
    r.idx = 2'd0;
    case (an)
      4'b1110: r.idx = 2'd0;
      4'b1101: r.idx = 2'd1;
      4'b1011: r.idx = 2'd2;
      4'b0111: r.idx = 2'd3;
      default: r.ok  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/scan_stable_filter.sv
// Synchronizes (an, sseg) and emits one accept per stable pair.
// Ports: clk, rst_n, an_i, sseg_i -> accept_o, an_o, sseg_o.
module scan_stable_filter
  import disp_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] an_i,
  input  logic [7:0] sseg_i,
  output logic       accept_o,
  output logic [3:0] an_o,
  output logic [7:0] sseg_o
);

  localparam int K =
    (STABLE_CYCLES < STABLE_MIN) ? STABLE_MIN :
    (STABLE_CYCLES > STABLE_MAX) ? STABLE_MAX :
    STABLE_CYCLES;
  localparam logic [7:0] K_SAT = 8'(K);
  localparam logic [7:0] K_ACC = 8'(K - 1);

  logic [11:0] sync_q [SYNC_STAGES];
  logic        vld_q  [SYNC_STAGES];
  logic [11:0] prev_q;
  logic        prev_vld_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [11:0] pair;
  logic        pair_vld;
  logic        same;

  assign pair     = sync_q[SYNC_STAGES-1];
  assign pair_vld = vld_q[SYNC_STAGES-1];

  // Valid bits ride along the synchronizer so the
  // reset value is never mistaken for a stable pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
        vld_q[i]  <= 1'b0;
      end
    end else begin
      sync_q[0] <= {an_i, sseg_i};
      vld_q[0]  <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
    end
  end

  assign same = pair_vld && prev_vld_q && (pair == prev_q);

  // Saturating at K keeps K-1 a single-cycle match.
  always_comb begin
    cnt_d = 8'd0;
    if (same) begin
      cnt_d = (cnt_q == K_SAT) ? cnt_q : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      prev_q     <= pair;
      prev_vld_q <= pair_vld;
      cnt_q      <= cnt_d;
    end
  end

  assign accept_o = (cnt_q == K_ACC);
  assign an_o     = prev_q[11:8];
  assign sseg_o   = prev_q[7:0];

endmodule

// File: rtl/disp_scan_capture.sv
// Reassembles a 4-digit frame from a multiplexed 7-seg scan.
// Ports: clk, rst_n, an, sseg, frame_ready -> digits, dps,
// legal, frame_valid, overrun, err_anode.
module disp_scan_capture
  import disp_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [7:0]  sseg,
  output logic [15:0] digits,
  output logic [3:0]  dps,
  output logic [3:0]  legal,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        overrun,
  output logic        err_anode
);

  logic       acc;
  logic [3:0] f_an;
  logic [7:0] f_seg;

  scan_stable_filter #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_filt (
    .clk      (clk),
    .rst_n    (rst_n),
    .an_i     (an),
    .sseg_i   (sseg),
    .accept_o (acc),
    .an_o     (f_an),
    .sseg_o   (f_seg)
  );

  an_dec_t  ad;
  seg_dec_t sd;

  assign ad = an_decode(f_an);
  assign sd = seg_decode(f_seg[6:0]);

  logic [0:0]  state_q, state_d;
  logic [1:0]  exp_q, exp_d;
  logic [15:0] sdig_q, sdig_d;
  logic [3:0]  sdp_q, sdp_d;
  logic [3:0]  slg_q, slg_d;
  logic        store;
  logic        complete;
  logic        err_d;
  logic        hs;

  // Digit 0 always (re)starts a frame, which also covers
  // the out-of-order case that lands on digit 0.
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    store    = 1'b0;
    complete = 1'b0;
    err_d    = 1'b0;
    if (acc) begin
      unique case (1'b1)
        !ad.ok: begin
          err_d   = 1'b1;
          state_d = ST_HUNT;
          exp_d   = 2'd0;
        end
        ad.ok && ad.idx == 2'd0: begin
          store   = 1'b1;
          state_d = ST_CAPTURE;
          exp_d   = 2'd1;
        end
        ad.ok && ad.idx != 2'd0
          && state_q == ST_CAPTURE
          && ad.idx == exp_q: begin
          store    = 1'b1;
          exp_d    = exp_q + 2'd1;
          complete = (exp_q == 2'd3);
        end
        default: begin
          state_d = ST_HUNT;
          exp_d   = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    sdig_d = sdig_q;
    sdp_d  = sdp_q;
    slg_d  = slg_q;
    if (store) begin
      sdig_d[{ad.idx, 2'b00} +: 4] = sd.val;
      sdp_d[ad.idx]                = ~f_seg[7];
      slg_d[ad.idx]                = sd.ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HUNT;
      exp_q   <= 2'd0;
      sdig_q  <= 16'hFFFF;
      sdp_q   <= 4'h0;
      slg_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      sdig_q  <= sdig_d;
      sdp_q   <= sdp_d;
      slg_q   <= slg_d;
    end
  end

  assign hs = frame_valid & frame_ready;

  // A completion on a handshake cycle refills the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits      <= 16'hFFFF;
      dps         <= 4'h0;
      legal       <= 4'h0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      err_anode   <= 1'b0;
    end else begin
      err_anode <= err_d;
      if (complete) begin
        if (!frame_valid || hs) begin
          digits      <= sdig_d;
          dps         <= sdp_d;
          legal       <= slg_d;
          frame_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (hs) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/disp_scan_capture.md
DISP_SCAN_CAPTURE -- requirements
Module: disp_scan_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive unchanged synchronized cycles before an (an, sseg) pair is accepted, legal range 2..255.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: number of input synchronizer flops.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port an, input, 4 bits: active-low digit select from the multiplexed display driver, an[i] low selects digit i.
REQ-006 SHALL have port sseg, input, 8 bits: active-low segments, with sseg[0]=a through sseg[6]=g and sseg[7]=dp.
REQ-007 SHALL have port digits, output, 16 bits: captured BCD frame, with digits[4i+3:4i] holding digit i.
REQ-008 SHALL have port dps, output, 4 bits: captured decimal points, active-high.
REQ-009 SHALL have port legal, output, 4 bits: legal[i] high when digit i decoded to 0..9.
REQ-010 SHALL have port frame_valid, output, 1 bit: a frame is available.
REQ-011 SHALL have port frame_ready, input, 1 bit: consumer accepts the frame.
REQ-012 SHALL have port overrun, output, 1 bit: sticky flag, set when a frame is lost.
REQ-013 SHALL have port err_anode, output, 1 bit: one-cycle pulse when an accepted pair has zero or more than one an bit low.

Function
REQ-014 SHALL pass an and sseg through SYNC_STAGES flops; all following logic SHALL use only the synchronized values.
REQ-015 SHALL count cycles in which the synchronized pair equals the previous cycle's pair, restarting at 0 on any change.
REQ-016 SHALL raise one accept event when the count reaches STABLE_CYCLES-1, with no further accept until the pair changes.
REQ-017 Latency from a stable input change to its accept event SHALL be SYNC_STAGES+STABLE_CYCLES cycles.
REQ-018 SHALL decode sseg[6:0] per this table, and any other code SHALL give value 4'hF with legal=0: 0x40->0, 0x79->1, 0x24->2, 0x30->3, 0x19->4, 0x12->5, 0x02->6, 0x78->7, 0x00->8, 0x10->9.
REQ-019 SHALL implement the state machine HUNT / CAPTURE, with a 2-bit expected index exp.
REQ-020 In HUNT, an accept with an=4'b1110 SHALL store digit 0, set exp=1 and go to CAPTURE; all other accepts SHALL be ignored.
REQ-021 In CAPTURE, an accept selecting digit exp SHALL store that digit; if exp=3, the staged frame SHALL be completed and exp wrapped to 0.
REQ-022 In CAPTURE, an accept selecting a digit other than exp SHALL return to HUNT, discard the staged frame, and leave outputs unchanged; if that digit is 0 it SHALL be re-handled per REQ-020 in the same cycle.
REQ-023 An accept with an illegal anode pattern SHALL pulse err_anode and return to HUNT.
REQ-024 On frame completion, the staged frame SHALL copy to digits/dps/legal and frame_valid SHALL assert on the next cycle.
REQ-025 frame_valid SHALL hold, with digits/dps/legal stable, until a cycle with frame_valid and frame_ready both high; it SHALL deassert on the following cycle.
REQ-026 If a frame completes while frame_valid=1 and frame_ready=0, the new frame SHALL be dropped and overrun set.
REQ-027 If completion coincides with a handshake cycle, the new frame SHALL load and frame_valid SHALL stay high.
REQ-028 overrun SHALL clear only on reset.

Reset
REQ-029 Asserting rst_n low SHALL at any time, including mid-frame, immediately force: state=HUNT, exp=0, counters and synchronizers cleared, digits=16'hFFFF, dps=0, legal=0, frame_valid=0, overrun=0, err_anode=0.
REQ-030 After rst_n rises, the first accept SHALL occur no earlier than SYNC_STAGES+STABLE_CYCLES cycles later.

Structure
REQ-031 The segment code table, the state encoding and STABLE_CYCLES bounds SHALL live in the shared package disp_pkg.
REQ-032 The synchronizer plus stability filter SHALL be one sub-module, scan_stable_filter; decode and FSM SHALL stay in the top module.

Verification
REQ-033 Scan digits 1,2,3,4 (each held 8 cycles, frame_ready=1): frame_valid pulses once, with digits=16'h4321, legal=4'hF, dps=0.
REQ-034 Glitch: toggle sseg for 2 cycles mid-digit with STABLE_CYCLES=4: no extra accept occurs, and the captured value is unchanged.
REQ-035 Scan order 0,2: the FSM returns to HUNT, no frame is produced, and the next clean 0..3 scan yields a correct frame.
REQ-036 Hold frame_ready=0 across two complete frames: the first frame is held, overrun=1, and the second frame is dropped.
REQ-037 Apply an=4'b1100: err_anode pulses once, and the FSM goes to HUNT.
REQ-038 Assert rst_n low during digit 2: outputs immediately take reset values, and capture resumes after the next digit 0.
